// File: rtl/projectile_pool_pkg.sv
// Shared types and helpers for the multi-shot projectile pool.
// PROJ_ARC_EN adds a vertical velocity field to each slot.
package projectile_pool_pkg;

  localparam int unsigned COORD_W      = 10;
  localparam int unsigned SCREEN_X_MAX = 639;
  localparam int unsigned SCREEN_Y_MAX = 479;

  typedef struct packed {
    logic               active;
    logic               dir;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
`ifdef PROJ_ARC_EN
    logic [5:0]         vy;
`endif
  } proj_slot_t;

  function automatic logic [COORD_W-1:0] abs_diff10(input logic [COORD_W-1:0] a,
                                                    input logic [COORD_W-1:0] b);
    return (a >= b) ? a - b : b - a;
  endfunction

endpackage

// File: rtl/projectile_pool_if.sv
// Frame, fire, geometry and status signals between the game logic and the projectile pool.
interface projectile_pool_if #(
  parameter int unsigned CNT_W = 3
);
  logic             frame_clk;
  logic             Fire;
  logic             Facing_Left;
  logic [9:0]       Shooter_X;
  logic [9:0]       Shooter_Y;
  logic [9:0]       Target_X;
  logic [9:0]       Target_Y;
  logic [9:0]       Target_Size;
  logic [9:0]       DrawX;
  logic [9:0]       DrawY;
  logic             is_proj;
  logic             hit_pulse;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] active_count;
  logic             full;

  modport master (
    output frame_clk, Fire, Facing_Left, Shooter_X, Shooter_Y,
           Target_X, Target_Y, Target_Size, DrawX, DrawY,
    input  is_proj, hit_pulse, hit_count, active_count, full
  );

  modport slave (
    input  frame_clk, Fire, Facing_Left, Shooter_X, Shooter_Y,
           Target_X, Target_Y, Target_Size, DrawX, DrawY,
    output is_proj, hit_pulse, hit_count, active_count, full
  );
endinterface

// File: rtl/projectile_pool_proj_slot.sv
// One projectile slot: per-tick move, bound retire, target hit and spawn load.
// PROJ_ARC_EN enables the ballistic vertical motion and ground retire.
module proj_slot
  import projectile_pool_pkg::*;
#(
  parameter int unsigned X_STEP   = 4,
  parameter int unsigned X_MIN    = 0,
  parameter int unsigned X_MAX    = SCREEN_X_MAX
`ifdef PROJ_ARC_EN
  ,
  parameter int unsigned ARC_VY0  = 6,
  parameter int unsigned GROUND_Y = 400
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       load,
  input  logic       load_dir,
  input  logic [9:0] load_x,
  input  logic [9:0] load_y,
  input  logic [9:0] target_x,
  input  logic [9:0] target_y,
  input  logic [9:0] target_size,
  output proj_slot_t slot,
  output logic       active_nxt_c,
  output logic       hit_c
);

  proj_slot_t nxt;
  logic       keep;
  logic [9:0] mx;
  logic [9:0] my;
`ifdef PROJ_ARC_EN
  logic signed [11:0] ny;
  logic [5:0]         nvy;
`endif

  // Bounds are tested on pre-move x so a left-moving shot never wraps.
  always_comb begin
    nxt   = slot;
    hit_c = 1'b0;
    keep  = 1'b0;
    mx    = slot.x;
    my    = slot.y;
    if (slot.dir) begin
      keep = slot.x >= 10'(X_MIN + X_STEP);
      mx   = slot.x - 10'(X_STEP);
    end else begin
      keep = (11'(slot.x) + 11'(X_STEP)) <= 11'(X_MAX);
      mx   = slot.x + 10'(X_STEP);
    end
`ifdef PROJ_ARC_EN
    ny  = $signed({2'b00, slot.y}) + $signed({{6{slot.vy[5]}}, slot.vy});
    nvy = (slot.vy == 6'd15) ? slot.vy : slot.vy + 6'd1;
    my  = ny[9:0];
    if (ny[11] || (ny >= $signed(12'(GROUND_Y)))) keep = 1'b0;
`endif
    if (tick) begin
      if (slot.active) begin
        if (keep) begin
          nxt.x = mx;
          nxt.y = my;
`ifdef PROJ_ARC_EN
          nxt.vy = nvy;
`endif
          if ((abs_diff10(mx, target_x) <= target_size) &&
              (abs_diff10(my, target_y) <= target_size)) begin
            hit_c      = 1'b1;
            nxt.active = 1'b0;
          end
        end else begin
          nxt.active = 1'b0;
        end
      end else if (load) begin
        nxt.active = 1'b1;
        nxt.dir    = load_dir;
        nxt.x      = load_x;
        nxt.y      = load_y;
`ifdef PROJ_ARC_EN
        nxt.vy     = -6'(ARC_VY0);
`endif
      end
    end
    active_nxt_c = nxt.active;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) slot <= '0;
    else     slot <= nxt;
  end

endmodule

// File: rtl/projectile_pool.sv
// Multi-shot projectile pool: frame tick detect, fire capture, cooldown, slot allocation and status.
// Optional macro PROJ_ARC_EN gives projectiles a ballistic arc.
module projectile_pool
  import projectile_pool_pkg::*;
#(
  parameter int unsigned NUM_PROJ        = 4,
  parameter int unsigned X_STEP          = 4,
  parameter int unsigned PROJ_SIZE       = 4,
  parameter int unsigned X_MIN           = 0,
  parameter int unsigned X_MAX           = SCREEN_X_MAX,
  parameter int unsigned COOLDOWN_FRAMES = 8
`ifdef PROJ_ARC_EN
  ,
  parameter int unsigned ARC_VY0         = 6,
  parameter int unsigned GROUND_Y        = 400
`endif
) (
  input logic               Clk,
  input logic               Reset,
  projectile_pool_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(NUM_PROJ + 1);
  localparam int unsigned CD_W  = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

  proj_slot_t          slot_q [NUM_PROJ];
  logic [NUM_PROJ-1:0] load_c;
  logic [NUM_PROJ-1:0] hit_c;
  logic [NUM_PROJ-1:0] active_nxt_c;
  logic                frame_q;
  logic                fire_q;
  logic                fire_pending;
  logic [CD_W-1:0]     cooldown;
  logic                hit_pulse_q;
  logic                full_q;
  logic [CNT_W-1:0]    hit_count_q;
  logic [CNT_W-1:0]    active_count_q;
  logic [CNT_W-1:0]    hit_sum_c;
  logic [CNT_W-1:0]    active_sum_c;
  logic                tick_c;
  logic                spawn_c;
  logic                free_found_c;
  logic                is_proj_c;

  assign tick_c = bus.frame_clk & ~frame_q;

  // Priority encoder: only slots free at the start of the tick may be loaded.
  always_comb begin
    load_c       = '0;
    free_found_c = 1'b0;
    for (int i = 0; i < NUM_PROJ; i++) begin
      if (!free_found_c && !slot_q[i].active) begin
        load_c[i]    = 1'b1;
        free_found_c = 1'b1;
      end
    end
    spawn_c = tick_c & fire_pending & (cooldown == '0) & free_found_c;
    load_c  = load_c & {NUM_PROJ{spawn_c}};
  end

  for (genvar g = 0; g < NUM_PROJ; g++) begin : g_slot
    proj_slot #(
      .X_STEP   (X_STEP),
      .X_MIN    (X_MIN),
      .X_MAX    (X_MAX)
`ifdef PROJ_ARC_EN
      ,
      .ARC_VY0  (ARC_VY0),
      .GROUND_Y (GROUND_Y)
`endif
    ) u_slot (
      .clk          (Clk),
      .rst          (Reset),
      .tick         (tick_c),
      .load         (load_c[g]),
      .load_dir     (bus.Facing_Left),
      .load_x       (bus.Shooter_X),
      .load_y       (bus.Shooter_Y),
      .target_x     (bus.Target_X),
      .target_y     (bus.Target_Y),
      .target_size  (bus.Target_Size),
      .slot         (slot_q[g]),
      .active_nxt_c (active_nxt_c[g]),
      .hit_c        (hit_c[g])
    );
  end

  // Population counts and the pixel coverage OR.
  always_comb begin
    hit_sum_c    = '0;
    active_sum_c = '0;
    is_proj_c    = 1'b0;
    for (int i = 0; i < NUM_PROJ; i++) begin
      hit_sum_c    = hit_sum_c + CNT_W'(hit_c[i]);
      active_sum_c = active_sum_c + CNT_W'(active_nxt_c[i]);
      if (slot_q[i].active &&
          (abs_diff10(bus.DrawX, slot_q[i].x) <= 10'(PROJ_SIZE)) &&
          (abs_diff10(bus.DrawY, slot_q[i].y) <= 10'(PROJ_SIZE)))
        is_proj_c = 1'b1;
    end
  end

  // Every tick consumes a pending request: spawned, blocked by cooldown, or discarded when full.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      frame_q        <= 1'b0;
      fire_q         <= 1'b0;
      fire_pending   <= 1'b0;
      cooldown       <= '0;
      hit_pulse_q    <= 1'b0;
      hit_count_q    <= '0;
      active_count_q <= '0;
      full_q         <= 1'b0;
    end else begin
      frame_q        <= bus.frame_clk;
      fire_q         <= bus.Fire;
      active_count_q <= active_sum_c;
      full_q         <= (active_sum_c == CNT_W'(NUM_PROJ));
      hit_pulse_q    <= tick_c & (|hit_c);
      if (tick_c) hit_count_q <= hit_sum_c;
      if (bus.Fire & ~fire_q) fire_pending <= 1'b1;
      else if (tick_c)        fire_pending <= 1'b0;
      if (tick_c) begin
        if (spawn_c)              cooldown <= CD_W'(COOLDOWN_FRAMES);
        else if (cooldown != '0)  cooldown <= cooldown - CD_W'(1);
      end
    end
  end

  assign bus.is_proj      = is_proj_c;
  assign bus.hit_pulse    = hit_pulse_q;
  assign bus.hit_count    = hit_count_q;
  assign bus.active_count = active_count_q;
  assign bus.full         = full_q;

endmodule

// File: tb/tb_projectile_pool.sv
// Scoreboard bench for projectile_pool (default parameters, PROJ_ARC_EN undefined).
module tb_projectile_pool;

  logic Clk = 1'b0;
  logic Reset;

  projectile_pool_if #(.CNT_W(3)) bus ();

  projectile_pool dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int id;
    int act;
    int full;
    int hc;
    int isp;
  } exp_t;

  exp_t q[$];
  int   errors  = 0;
  int   checks  = 0;
  int   tick_id = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: each frame rise is followed by the tick edge; sample on the next falling edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge bus.frame_clk);
      @(posedge Clk);
      @(negedge Clk);
      if (q.size() == 0) begin
        check("scoreboard_empty", 1, 0);
      end else begin
        e = q.pop_front();
        check($sformatf("active_count t%0d", e.id), int'(bus.active_count), e.act);
        check($sformatf("full t%0d", e.id), int'(bus.full), e.full);
        check($sformatf("hit_count t%0d", e.id), int'(bus.hit_count), e.hc);
        check($sformatf("hit_pulse t%0d", e.id), int'(bus.hit_pulse), (e.hc != 0) ? 1 : 0);
        check($sformatf("is_proj t%0d", e.id), int'(bus.is_proj), e.isp);
      end
      @(negedge Clk);
      check($sformatf("hit_pulse_width t%0d", tick_id), int'(bus.hit_pulse), 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic frame(input int dx, input int dy, input int ea, input int ef,
                       input int eh, input int ei);
    bus.DrawX = 10'(dx);
    bus.DrawY = 10'(dy);
    tick_id++;
    q.push_back('{tick_id, ea, ef, eh, ei});
    @(posedge Clk); #1 bus.frame_clk = 1'b1;
    repeat (3) @(posedge Clk);
    #1 bus.frame_clk = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
  endtask

  task automatic fire();
    @(posedge Clk); #1 bus.Fire = 1'b1;
    repeat (2) @(posedge Clk);
    #1 bus.Fire = 1'b0;
    @(posedge Clk); #1;
  endtask

  task automatic do_reset();
    bus.Fire      = 1'b0;
    bus.frame_clk = 1'b0;
    @(posedge Clk); #1 Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    check("rst active_count", int'(bus.active_count), 0);
    check("rst full", int'(bus.full), 0);
    check("rst hit_pulse", int'(bus.hit_pulse), 0);
    check("rst hit_count", int'(bus.hit_count), 0);
    check("rst is_proj", int'(bus.is_proj), 0);
    Reset = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
  endtask

  task automatic set_target(input int x, input int y, input int s);
    bus.Target_X    = 10'(x);
    bus.Target_Y    = 10'(y);
    bus.Target_Size = 10'(s);
  endtask

  task automatic set_shooter(input int x, input int y, input logic left);
    bus.Shooter_X   = 10'(x);
    bus.Shooter_Y   = 10'(y);
    bus.Facing_Left = left;
  endtask

  initial begin
    int ea;
    Reset         = 1'b1;
    bus.frame_clk = 1'b0;
    bus.Fire      = 1'b0;
    bus.DrawX     = '0;
    bus.DrawY     = '0;
    set_target(600, 50, 5);
    set_shooter(100, 375, 1'b0);

    // Reset and an idle frame
    do_reset();
    frame(100, 375, 0, 0, 0, 0);

    // Single shot: spawn in place, then step right; 5 px away is outside the square
    fire();
    frame(100, 375, 1, 0, 0, 1);
    frame(108, 375, 1, 0, 0, 1);
    frame(113, 375, 1, 0, 0, 0);

    // Reset mid-flight with the pixel on a live shot
    bus.DrawX = 10'd112;
    do_reset();

    // Fire before every tick: cooldown allows spawns on ticks 1, 10, 19, 28 -> full
    for (int k = 1; k <= 37; k++) begin
      fire();
      ea = (k >= 28) ? 4 : (k >= 19) ? 3 : (k >= 10) ? 2 : 1;
      frame(100 + 4 * (k - 1), 375, ea, (k >= 28) ? 1 : 0, 0, 1);
    end
    // Slot 0 (x=248) hits; the request on that tick is discarded since no slot was free at its start
    set_target(248, 375, 0);
    fire();
    frame(248, 375, 3, 0, 1, 0);
    set_target(600, 50, 5);
    fire();
    frame(100, 375, 4, 1, 0, 1);
    fire();
    frame(100, 375, 4, 1, 0, 1);

    // Hit at x=180 against a 20 px box centred on 200
    do_reset();
    set_target(200, 375, 20);
    fire();
    for (int k = 1; k <= 20; k++) frame(100 + 4 * (k - 1), 375, 1, 0, 0, 1);
    frame(180, 375, 0, 0, 1, 0);
    frame(180, 375, 0, 0, 0, 0);

    // Left-moving shot from x=6: moves to 2, then retires instead of wrapping
    do_reset();
    set_target(600, 50, 5);
    set_shooter(6, 200, 1'b1);
    fire();
    frame(6, 200, 1, 0, 0, 1);
    frame(2, 200, 1, 0, 0, 1);
    frame(2, 200, 0, 0, 0, 0);

    // Right bound: 630 -> 634 -> 638, then 642 exceeds 639 and retires
    do_reset();
    set_shooter(630, 200, 1'b0);
    fire();
    frame(630, 200, 1, 0, 0, 1);
    frame(634, 200, 1, 0, 0, 1);
    frame(638, 200, 1, 0, 0, 1);
    frame(638, 200, 0, 0, 0, 0);

    repeat (4) @(posedge Clk);
    check("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
